// File: rtl/sequence_generator.sv
// Stimulus source for a button/x/y symbol detector: emits one of two fixed
// three-symbol sequences as SETUP / PRESS / GAP phases per symbol, then a done pulse.
module sequence_generator #(
  parameter logic [31:0] SETUP_CYCLES = 32'd0_010_000,
  parameter logic [31:0] PRESS_CYCLES = 32'd0_600_000,
  parameter logic [31:0] GAP_CYCLES   = 32'd0_100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sel,
  input  logic abort,
  output logic x,
  output logic y,
  output logic button,
  output logic busy,
  output logic done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [1:0]  xy_q, xy_d;
  logic        button_q, button_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        active;

  // Sequence A is (1,0),(1,0),(1,1); sequence B is (1,1) three times.
  function automatic logic [1:0] symbol(input logic s, input logic [1:0] i);
    return (s || (i == 2'd2)) ? 2'b11 : 2'b10;
  endfunction

  assign active = (state_q == S_SETUP) || (state_q == S_PRESS) || (state_q == S_GAP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    xy_d    = xy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        idx_d = 2'd0;
        xy_d  = 2'b00;
        if (start) begin
          sel_d   = sel;
          xy_d    = symbol(sel, 2'd0);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_CYCLES - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = S_PRESS;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PRESS: begin
        if (cnt_q == PRESS_CYCLES - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_CYCLES - 32'd1) begin
          cnt_d = 32'd0;
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            xy_d    = 2'b00;
            state_d = S_DONE;
          end else begin
            // x/y only move here, on entry to SETUP, so they are stable around every press.
            idx_d   = idx_q + 2'd1;
            xy_d    = symbol(sel_q, idx_q + 2'd1);
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        cnt_d   = 32'd0;
        idx_d   = 2'd0;
        xy_d    = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 32'd0;
        idx_d   = 2'd0;
        xy_d    = 2'b00;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever phase transition was due on this edge.
    if (abort && active) begin
      state_d = S_IDLE;
      cnt_d   = 32'd0;
      idx_d   = 2'd0;
      xy_d    = 2'b00;
    end

    button_d = (state_d == S_PRESS);
    busy_d   = (state_d == S_SETUP) || (state_d == S_PRESS) || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= 32'd0;
      sel_q    <= 1'b0;
      xy_q     <= 2'b00;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      xy_q     <= xy_d;
      button_q <= button_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = xy_q[1];
  assign y      = xy_q[0];
  assign button = button_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator with SETUP=2, PRESS=4, GAP=3 (9-cycle symbol period).
module tb_sequence_generator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic abort = 1'b0;
  logic x, y, button, busy, done;

  sequence_generator #(
    .SETUP_CYCLES(32'd2),
    .PRESS_CYCLES(32'd4),
    .GAP_CYCLES  (32'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sel   (sel),
    .abort (abort),
    .x     (x),
    .y     (y),
    .button(button),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    sel;
    bit    abort_with_start;
    int    abort_at;   // 0 = no abort; else abort high during that cycle
    bit    repulse;    // re-pulse start at 5/20 and toggle sel at 10
    int    exp_done;   // expected number of done pulses
  } scenario_t;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  // {x, y, button, busy, done} expected for cycle n after the start-accept edge.
  function automatic logic [4:0] exp_vec(int n, bit s, int abort_at);
    logic ex, ey, eb, ed;
    if (abort_at > 0 && n > abort_at) return 5'b0;
    ex = (n >= 1 && n <= 27);
    ey = s ? ex : (n >= 19 && n <= 27);
    eb = (n >= 3 && n <= 6) || (n >= 12 && n <= 15) || (n >= 21 && n <= 24);
    ed = (n == 28);
    return {ex, ey, eb, ex, ed};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got xy_btn_busy_done=%b expected %b", name, act, expv);
    end
  endtask

  task automatic check_next(input string name, input int n);
    logic [4:0] expv;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s cycle %0d: scoreboard empty, got %b expected an entry", name, n,
               {x, y, button, busy, done});
    end else begin
      expv = exp_q.pop_front();
      check($sformatf("%s c%0d", name, n), {x, y, button, busy, done}, expv);
    end
  endtask

  // Entered at a negedge while the DUT is idle; leaves at the negedge of cycle 29.
  task automatic run_scenario(input scenario_t sc);
    int dones = 0;
    start = 1'b1;
    sel   = sc.sel;
    abort = sc.abort_with_start;
    for (int n = 1; n <= 29; n++) exp_q.push_back(exp_vec(n, sc.sel, sc.abort_at));
    for (int n = 1; n <= 29; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      check_next(sc.name, n);
      start = sc.repulse && (n == 5 || n == 20);
      if (sc.repulse && n == 10) sel = ~sel;
      abort = (n == sc.abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (dones != sc.exp_done) begin
      fails++;
      $display("[TB] FAIL %s done_count: got %0d expected %0d", sc.name, dones, sc.exp_done);
    end
    $display("[TB] %s: sel=%0d abort_at=%0d done pulses=%0d", sc.name, sc.sel, sc.abort_at, dones);
  endtask

  scenario_t table_v[10];

  initial begin
    table_v[0] = '{"seq_a",            1'b0, 1'b0, 0,  1'b0, 1};
    table_v[1] = '{"seq_b",            1'b1, 1'b0, 0,  1'b0, 1};
    table_v[2] = '{"abort_press2",     1'b0, 1'b0, 13, 1'b0, 0};
    table_v[3] = '{"seq_a_after_abort",1'b0, 1'b0, 0,  1'b0, 1};
    table_v[4] = '{"repulse_sel_flip", 1'b0, 1'b0, 0,  1'b1, 1};
    table_v[5] = '{"abort_setup_end",  1'b1, 1'b0, 2,  1'b0, 0};
    table_v[6] = '{"abort_last_gap",   1'b0, 1'b0, 27, 1'b0, 0};
    table_v[7] = '{"abort_in_done",    1'b1, 1'b0, 28, 1'b0, 1};
    table_v[8] = '{"start_abort_idle", 1'b0, 1'b1, 0,  1'b0, 1};
    table_v[9] = '{"abort_press1_end", 1'b1, 1'b0, 6,  1'b0, 0};

    // Asynchronous reset with no clock edge yet.
    #1 reset = 1'b1;
    #1 check("reset_state", {x, y, button, busy, done}, 5'b0);
    $display("[TB] reset applied, outputs=%b", {x, y, button, busy, done});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {x, y, button, busy, done}, 5'b0);

    foreach (table_v[i]) run_scenario(table_v[i]);

    // Reset in the middle of cycle 4 (first press) must drop button before the next edge.
    start = 1'b1;
    sel   = 1'b0;
    for (int n = 1; n <= 29; n++) exp_q.push_back(exp_vec(n, 1'b0, 0));
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check_next("async_rst_pre", n);
      start = 1'b0;
    end
    exp_q.delete();
    #1 reset = 1'b1;
    #1 check("async_rst_mid", {x, y, button, busy, done}, 5'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle c%0d", n), {x, y, button, busy, done}, 5'b0);
    end
    $display("[TB] async reset mid-press: outputs cleared, idle afterwards");

    // Start held high: back-to-back sequences with period 29, done at 28/57/86.
    start = 1'b1;
    sel   = 1'b0;
    for (int n = 1; n <= 87; n++) exp_q.push_back(exp_vec(((n - 1) % 29) + 1, 1'b0, 0));
    for (int n = 1; n <= 87; n++) begin
      @(negedge clk);
      check_next("start_held", n);
      if (done === 1'b1) $display("[TB] start_held: done at cycle %0d", n);
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
